// File: rtl/apb_master_ctrl.sv
// APB master: accepts single read/write commands, decodes to one of four slaves,
// runs SETUP/ACCESS with a pready timeout, and returns one response per command.
module apb_master_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
    parameter int unsigned SLV_SEL_LSB    = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  psel,
    output logic        penable,
    input  logic [31:0] mst_prdata,
    input  logic        mst_pready
);

    localparam int unsigned DecLsb      = SLV_SEL_LSB + 2;
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        dec_hit;
    logic [3:0]  dec_sel;

    assign dec_hit = (cmd_addr[31:DecLsb] == BASE_ADDR[31:DecLsb]);
    assign dec_sel = 4'b0001 << cmd_addr[SLV_SEL_LSB +: 2];

    assign cmd_ready = (state_q == StIdle) && !preset;

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (dec_hit) begin
                        paddr_d   = cmd_addr;
                        pwrite_d  = cmd_write;
                        pwdata_d  = cmd_wdata;
                        psel_d    = dec_sel;
                        penable_d = 1'b0;
                        state_d   = StSetup;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = 8'd0;
                state_d   = StAccess;
            end
            StAccess: begin
                // pready on the final count still completes the transfer normally
                if (mst_pready) begin
                    rsp_rdata_d = pwrite_q ? 32'h0 : mst_prdata;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 4'b0000;
                    penable_d   = 1'b0;
                    state_d     = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 4'b0000;
                    penable_d   = 1'b0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= StIdle;
            paddr_q     <= 32'h0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 32'h0;
            psel_q      <= 4'b0000;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: the bench plays the APB slave side and predicts each
// transaction (decode, wait states, timeout, response) from address/wait-count rules.
module tb_apb_master_ctrl;

    localparam logic [31:0] Base    = 32'h4000_0000;
    localparam int          Timeout = 16;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, mst_prdata;
    logic        pwrite, penable, mst_pready;
    logic [3:0]  psel;

    int n_checks = 0;
    int n_pass   = 0;

    apb_master_ctrl #(
        .BASE_ADDR     (Base),
        .SLV_SEL_LSB   (12),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .mst_prdata(mst_prdata),
        .mst_pready(mst_pready)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    // One full command: entered and left at a negedge with the DUT idle.
    // waits = pready-low ACCESS cycles before pready (>= Timeout means never).
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd, input int bp);
        logic        hit, tmo, e_err;
        logic [3:0]  e_sel;
        logic [31:0] e_rd;
        int          acc;
        hit   = (addr[31:14] == Base[31:14]);
        e_sel = 4'b0001 << addr[13:12];
        tmo   = hit && (waits >= Timeout);
        acc   = tmo ? Timeout : waits + 1;
        e_err = !hit || tmo;
        e_rd  = (hit && !tmo && !wr) ? rd : 32'h0;

        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_psel", 32'(psel), 32'd0);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        mst_pready = 1'($urandom);
        step();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        if (hit) begin
            check("setup_psel", 32'(psel), 32'(e_sel));
            check("setup_penable", 32'(penable), 32'd0);
            check("setup_paddr", paddr, addr);
            check("setup_pwrite", 32'(pwrite), 32'(wr));
            if (wr) check("setup_pwdata", pwdata, wd);
            check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
            mst_pready = 1'($urandom);
            for (int j = 0; j < acc; j++) begin
                step();
                check("access_psel", 32'(psel), 32'(e_sel));
                check("access_penable", 32'(penable), 32'd1);
                check("access_paddr", paddr, addr);
                if (wr) check("access_pwdata", pwdata, wd);
                check("access_rsp_valid", 32'(rsp_valid), 32'd0);
                mst_pready = (j == waits);
                mst_prdata = (j == waits) ? rd : $urandom;
            end
            step();
            mst_pready = 1'($urandom);
        end
        for (int b = 0; b <= bp; b++) begin
            check("resp_valid", 32'(rsp_valid), 32'd1);
            check("resp_err", 32'(rsp_err), 32'(e_err));
            check("resp_rdata", rsp_rdata, e_rd);
            check("resp_psel", 32'(psel), 32'd0);
            check("resp_penable", 32'(penable), 32'd0);
            check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
            // A pending command must not be taken while a response is held.
            rsp_ready = (b == bp);
            cmd_valid = (b != bp);
            cmd_addr  = Base + 32'h10;
            step();
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_psel", 32'(psel), 32'd0);
    endtask

    task automatic reset_mid_access();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = Base + 32'h1008;
        step();
        cmd_valid  = 1'b0;
        mst_pready = 1'b0;
        step();
        check("rst_pre_penable", 32'(penable), 32'd1);
        step();
        preset = 1'b1;
        step();
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
        preset = 1'b0;
        step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            mst_pready = 1'b1;
            step();
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
            check("rst_no_psel", 32'(psel), 32'd0);
        end
        mst_pready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        preset     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = 32'h0;
        cmd_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        mst_pready = 1'b0;
        mst_prdata = 32'h0;
        step();
        step();
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_psel", 32'(psel), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_paddr", paddr, 32'd0);
        preset = 1'b0;
        step();

        run_txn(1'b1, 32'h4000_2004, 32'hDEAD_BEEF, 0, 32'h0, 0);
        run_txn(1'b0, 32'h4000_0010, 32'h0, 3, 32'h1234_5678, 0);
        run_txn(1'b0, 32'h5000_0000, 32'h0, 0, 32'h0, 0);
        run_txn(1'b0, 32'h4000_3000, 32'h0, 255, 32'hCAFE_F00D, 0);
        run_txn(1'b0, 32'h4000_1000, 32'h0, Timeout - 1, 32'h0BAD_CAFE, 0);
        run_txn(1'b0, 32'h4000_2020, 32'h0, 1, 32'h5555_AAAA, 5);
        run_txn(1'b1, 32'h4000_4000, 32'h1, 0, 32'h0, 1);
        reset_mid_access();

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = Base | (a & 32'h0000_3FFC);
            run_txn(1'($urandom), a, $urandom, int'($urandom_range(0, 20)), $urandom,
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
